serial_receiver: RTL and testbench

Bit-serial receiver: the downstream counterpart of the serial transmitter. It recovers framed bytes from a single-wire serial line using a clock-divided bit timer. It checks parity and stop bits and presents each byte on a valid/ready output port with overrun detection. It sits at the receive end of the serial link and feeds the byte-level consumer.

---
 rtl/serial_receiver.sv | 164 ++++++++++++++++
 tb/tb_serial_receiver.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_receiver.sv
// Bit-serial receiver: recovers framed bytes (start, DATA_BITS LSB-first, optional even parity, stop).
// Latency: data_valid / error pulses appear the cycle after the stop-bit sample edge.
// Backpressure: one-entry holding register; a good frame arriving while it is full and not being accepted is dropped with an overrun pulse.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   serial_in         asynchronous serial line, idle high
//   data_out          received byte, meaningful while data_valid is high
//   data_valid        byte held until data_valid && data_ready
//   data_ready        consumer accept
//   parity_error      one-cycle pulse, parity mismatch (frame dropped)
//   framing_error     one-cycle pulse, stop bit low (frame dropped)
//   overrun           one-cycle pulse, good frame dropped because holding register was full
module serial_receiver #(
  parameter int DIVIDER   = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY_EN = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun
);

  localparam int CW = $clog2(DIVIDER);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_TC  = CW'(DIVIDER / 2 - 1);
  localparam logic [CW-1:0] FULL_TC  = CW'(DIVIDER - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;
  logic                 sync1;
  logic                 rx_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      par_bad       <= 1'b0;
      sync1         <= 1'b1;
      rx_s          <= 1'b1;
      data_out      <= '0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      sync1         <= serial_in;
      rx_s          <= sync1;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;

      // Acceptance clears the holding register; a delivery in the STOP
      // branch below overrides this when it reloads in the same cycle.
      if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state <= START;
          end
        end

        // Re-check at mid start bit so sub-half-bit glitches are ignored.
        START: begin
          if (cnt == HALF_TC) begin
            cnt     <= '0;
            bit_cnt <= '0;
            par_bad <= 1'b0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DATA: begin
          if (cnt == FULL_TC) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_cnt == LAST_BIT) begin
              state <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        // Even parity: the parity bit equals the XOR of the data bits.
        PARITY: begin
          if (cnt == FULL_TC) begin
            cnt     <= '0;
            par_bad <= (rx_s != ^shreg);
            state   <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        // A bad stop bit masks any latched parity error.
        STOP: begin
          if (cnt == FULL_TC) begin
            cnt <= '0;
            if (rx_s) begin
              if (par_bad) begin
                parity_error <= 1'b1;
              end else if (!data_valid || data_ready) begin
                data_out   <= shreg;
                data_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
              state <= IDLE;
            end else begin
              framing_error <= 1'b1;
              state         <= BREAK;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        // Line held low past the stop bit: wait for it to return to idle.
        BREAK: begin
          cnt <= '0;
          if (rx_s) begin
            state <= IDLE;
          end
        end

        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_receiver.sv
// Testbench for serial_receiver with DIVIDER=4, DATA_BITS=8, PARITY_EN=1.
module tb_serial_receiver;

  logic       clk;
  logic       reset;
  logic       serial_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       parity_error;
  logic       framing_error;
  logic       overrun;

  serial_receiver #(
    .DIVIDER  (4),
    .DATA_BITS(8),
    .PARITY_EN(1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .serial_in    (serial_in),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .parity_error (parity_error),
    .framing_error(framing_error),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Pulse / event counters, sampled away from the active edge.
  int  vcnt = 0;
  int  pcnt = 0;
  int  fcnt = 0;
  int  ocnt = 0;
  logic prev_vld = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (data_valid && !prev_vld) vcnt++;
      if (parity_error)  pcnt++;
      if (framing_error) fcnt++;
      if (overrun)       ocnt++;
    end
    prev_vld = data_valid;
  end

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stp;
    logic       exp_vld;
    logic [7:0] exp_dat;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one frame starting just after an edge; returns just after the
  // 44th edge, which is one edge before the receiver's stop sample.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    serial_in = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 8; i++) begin
      serial_in = d[i];
      repeat (4) tick();
    end
    serial_in = p;
    repeat (4) tick();
    serial_in = s;
    repeat (4) tick();
  endtask

  int snap_v, snap_p, snap_f, snap_o;

  initial begin
    //            data   par   stop  vld   dat    perr  ferr
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[4] = '{8'h3C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
    vecs[6] = '{8'h7E, 1'b0, 1'b1, 1'b1, 8'h7E, 1'b0, 1'b0};
    vecs[7] = '{8'h12, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};

    reset      = 1'b1;
    serial_in  = 1'b1;
    data_ready = 1'b1;
    repeat (3) tick();
    check("rst data_out", 32'(data_out), 32'h00);
    check("rst data_valid", 32'(data_valid), 0);
    check("rst parity_error", 32'(parity_error), 0);
    check("rst framing_error", 32'(framing_error), 0);
    check("rst overrun", 32'(overrun), 0);
    reset = 1'b0;
    repeat (4) tick();

    // Table-driven frames with exact delivery timing.
    for (int k = 0; k < 8; k++) begin
      send_frame(vecs[k].data, vecs[k].par, vecs[k].stp);
      serial_in = 1'b1;
      check($sformatf("v%0d valid early", k), 32'(data_valid), 0);
      check($sformatf("v%0d perr early", k), 32'(parity_error), 0);
      tick();
      check($sformatf("v%0d valid", k), 32'(data_valid), 32'(vecs[k].exp_vld));
      if (vecs[k].exp_vld) check($sformatf("v%0d data", k), 32'(data_out), 32'(vecs[k].exp_dat));
      check($sformatf("v%0d perr", k), 32'(parity_error), 32'(vecs[k].exp_perr));
      check($sformatf("v%0d ferr", k), 32'(framing_error), 32'(vecs[k].exp_ferr));
      check($sformatf("v%0d ovr", k), 32'(overrun), 0);
      tick();
      check($sformatf("v%0d valid after accept", k), 32'(data_valid), 0);
      check($sformatf("v%0d perr one cycle", k), 32'(parity_error), 0);
      check($sformatf("v%0d ferr one cycle", k), 32'(framing_error), 0);
      repeat (6) tick();
    end

    // Framing error, line held low, then recovery.
    snap_f = fcnt;
    snap_v = vcnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    tick();
    check("brk framing pulse", 32'(framing_error), 1);
    repeat (19) tick();
    check("brk framing count", fcnt, snap_f + 1);
    check("brk no data", vcnt, snap_v);
    serial_in = 1'b1;
    repeat (6) tick();
    send_frame(8'h55, 1'b0, 1'b1);
    serial_in = 1'b1;
    tick();
    check("brk recover valid", 32'(data_valid), 1);
    check("brk recover data", 32'(data_out), 32'h55);
    repeat (6) tick();

    // Glitch shorter than half a bit.
    snap_v = vcnt; snap_p = pcnt; snap_f = fcnt;
    serial_in = 1'b0;
    tick();
    serial_in = 1'b1;
    repeat (20) tick();
    check("glitch no data", vcnt, snap_v);
    check("glitch no perr", pcnt, snap_p);
    check("glitch no ferr", fcnt, snap_f);
    send_frame(8'hC3, 1'b0, 1'b1);
    serial_in = 1'b1;
    tick();
    check("glitch next valid", 32'(data_valid), 1);
    check("glitch next data", 32'(data_out), 32'hC3);
    repeat (6) tick();

    // Overrun, then accept coincident with delivery.
    data_ready = 1'b0;
    snap_o = ocnt;
    send_frame(8'h11, 1'b0, 1'b1);
    serial_in = 1'b1;
    tick();
    check("ovr first valid", 32'(data_valid), 1);
    check("ovr first data", 32'(data_out), 32'h11);
    repeat (4) tick();
    send_frame(8'h22, 1'b0, 1'b1);
    serial_in = 1'b1;
    tick();
    check("ovr pulse", 32'(overrun), 1);
    check("ovr data kept", 32'(data_out), 32'h11);
    check("ovr valid kept", 32'(data_valid), 1);
    tick();
    check("ovr pulse one cycle", 32'(overrun), 0);
    repeat (3) tick();
    send_frame(8'h33, 1'b0, 1'b1);
    serial_in  = 1'b1;
    data_ready = 1'b1;
    tick();
    check("simul data", 32'(data_out), 32'h33);
    check("simul valid", 32'(data_valid), 1);
    check("simul no ovr", 32'(overrun), 0);
    tick();
    check("simul accepted", 32'(data_valid), 0);
    check("ovr count", ocnt, snap_o + 1);
    repeat (6) tick();

    // Reset mid-frame drops the held byte and the partial frame.
    data_ready = 1'b0;
    send_frame(8'h81, 1'b0, 1'b1);
    serial_in = 1'b1;
    tick();
    check("rstmid held valid", 32'(data_valid), 1);
    check("rstmid held data", 32'(data_out), 32'h81);
    repeat (4) tick();
    serial_in = 1'b0;
    repeat (4) tick();
    serial_in = 1'b1;
    repeat (14) tick();
    reset = 1'b1;
    tick();
    check("rstmid data_out", 32'(data_out), 32'h00);
    check("rstmid valid", 32'(data_valid), 0);
    check("rstmid perr", 32'(parity_error), 0);
    check("rstmid ferr", 32'(framing_error), 0);
    check("rstmid ovr", 32'(overrun), 0);
    reset = 1'b0;
    snap_v = vcnt; snap_p = pcnt; snap_f = fcnt; snap_o = ocnt;
    repeat (20) tick();
    check("rstmid quiet valid", 32'(data_valid), 0);
    check("rstmid quiet pulses", pcnt + fcnt + ocnt, snap_p + snap_f + snap_o);
    data_ready = 1'b1;
    send_frame(8'h0F, 1'b0, 1'b1);
    serial_in = 1'b1;
    tick();
    check("rstmid next valid", 32'(data_valid), 1);
    check("rstmid next data", 32'(data_out), 32'h0F);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
